registrador_universal: RTL and testbench
========================================

REGISTRADOR_UNIVERSAL -- requirements
Module: registrador_universal

Interface
REQ-001 Parameter WIDTH, 8, data width of every register and of bus/ULA ports (legal 4..32).
REQ-002 Parameter NUM_REGS, 4, number of registers in the bank (legal 1..16).
REQ-003 Parameter SEL_W, $clog2(NUM_REGS) (min 1), width of every select port.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clock is the single clock and clear is the reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 clear  input  1  asynchronous active-high reset.
REQ-007 op_en  input  1  execute op on reg[wr_sel] at the next rising edge.
REQ-008 op  input  3  operation code (encodings in REQ-013).
REQ-009 wr_sel  input  SEL_W  target register of op.
REQ-010 bus_in  input  WIDTH  load data.
REQ-011 serial_in  input  1  fill bit for SHL/SHR.
REQ-012 out_en  input  1  drive bus_out; ula_sel / out_sel  input  SEL_W  read selects; bus_out  output  WIDTH  tristate bus; TO_ULA  output  WIDTH  always-driven ULA operand; zero_flag / carry_flag  output  1  status of last executed op.

Function
REQ-013 op encodings SHALL be: 000 HOLD, 001 LOAD (bus_in), 010 INC (+1), 011 DEC (-1), 100 SHL ({r[W-2:0],serial_in}), 101 SHR ({serial_in,r[W-1:1]}), 110 ROTL ({r[W-2:0],r[W-1]}), 111 CLR (0).
REQ-014 With op_en=1 at a rising edge and wr_sel < NUM_REGS, reg[wr_sel] SHALL take the op result; all other registers SHALL hold.
REQ-015 op_en=0, op=HOLD, or wr_sel >= NUM_REGS SHALL change no register and no flag.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH: INC of all-ones gives 0, DEC of 0 gives all-ones.
REQ-017 carry_flag SHALL be set to: INC wrap-out (old==all-ones), DEC borrow (old==0), SHL/ROTL old MSB, SHR old LSB, 0 for LOAD/CLR.
REQ-018 zero_flag SHALL be set to (result == 0) for every executed non-HOLD op.
REQ-019 Flags SHALL update on the same edge as the register write (latency 1 cycle) and hold otherwise.
REQ-020 TO_ULA SHALL equal reg[ula_sel] combinationally; out-of-range ula_sel SHALL yield 0.
REQ-021 bus_out SHALL equal reg[out_sel] when out_en=1 (out-of-range gives 0), else high-impedance on all bits.
REQ-022 Read-during-write: TO_ULA/bus_out SHALL show the old value until the write edge, new value after it (no bypass).
REQ-023 Operations SHALL be single-cycle; back-to-back ops on consecutive edges on the same register SHALL each see the previous result.

Reset
REQ-024 clear=1 SHALL immediately, without clock, force all registers to 0, zero_flag=0, carry_flag=0.
REQ-025 clear asserted during an op edge SHALL win; the op SHALL be discarded.
REQ-026 During reset TO_ULA SHALL read 0 and bus_out SHALL follow out_en (0 or Z).
REQ-027 The first rising edge after clear falls SHALL execute normally.

Structure
REQ-028 The op encodings (3-bit opcode type and named constants) SHALL live in the shared package sap_pkg.
REQ-029 One sub-module registrador_celula (one WIDTH-bit register with op datapath, write enable, carry/zero outputs) SHALL be instantiated NUM_REGS times; the top SHALL hold select decode, flag registers and read muxes.

Verification
REQ-030 WIDTH=8,NUM_REGS=4: LOAD 0xA5 to r2, ula_sel=2 -> TO_ULA=0xA5 one edge later; r0,r1,r3 remain 0x00; zero=0, carry=0.
REQ-031 LOAD 0xFF to r1 then INC r1 -> r1=0x00, zero=1, carry=1; then DEC r1 -> 0xFF, zero=0, carry=1.
REQ-032 r0=0x81: SHL serial_in=0 -> 0x02 carry=1; SHR serial_in=1 -> 0x81 carry=0; ROTL -> 0x03 carry=1.
REQ-033 out_en=0 -> bus_out all Z; out_en=1, out_sel=2 with r2=0x3C -> bus_out=0x3C; NUM_REGS=3, wr_sel=3 LOAD -> no register or flag change.
REQ-034 clear pulsed mid-cycle coincident with LOAD 0x55 -> all regs 0x00 and flags 0 without waiting for an edge; LOAD on first edge after release -> value stored.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared opcode definitions for the universal register bank.
package sap_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROTL = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

endpackage

// File: rtl/registrador_celula.sv
// One WIDTH-bit register with its own op datapath; carry/zero describe the
// result the current op would produce, so the top can latch them on write.
module registrador_celula import sap_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             we_i,
  input  op_t              op_i,
  input  logic [WIDTH-1:0] bus_in_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             carry_d;

  always_comb begin
    reg_d   = reg_q;
    carry_d = 1'b0;
    case (op_i)
      OP_HOLD: reg_d = reg_q;
      OP_LOAD: reg_d = bus_in_i;
      OP_INC: begin
        reg_d   = reg_q + 1'b1;
        carry_d = &reg_q;
      end
      OP_DEC: begin
        reg_d   = reg_q - 1'b1;
        carry_d = ~|reg_q;
      end
      OP_SHL: begin
        reg_d   = {reg_q[WIDTH-2:0], serial_in_i};
        carry_d = reg_q[WIDTH-1];
      end
      OP_SHR: begin
        reg_d   = {serial_in_i, reg_q[WIDTH-1:1]};
        carry_d = reg_q[0];
      end
      OP_ROTL: begin
        reg_d   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        carry_d = reg_q[WIDTH-1];
      end
      OP_CLR:  reg_d = '0;
      default: reg_d = reg_q;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) reg_q <= '0;
    else if (we_i) reg_q <= reg_d;
  end

  assign q_o     = reg_q;
  assign carry_o = carry_d;
  assign zero_o  = (reg_d == '0);

endmodule

// File: rtl/registrador_universal.sv
// Register bank: select decode, status flags and the ULA / tristate bus read
// ports around NUM_REGS registrador_celula instances.
module registrador_universal import sap_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             op_en,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             serial_in,
  input  logic             out_en,
  input  logic [SEL_W-1:0] ula_sel,
  input  logic [SEL_W-1:0] out_sel,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] TO_ULA,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam int unsigned NR = NUM_REGS;

  op_t                 op_c;
  logic [WIDTH-1:0]    cell_q [NR];
  logic [NR-1:0]       we, cell_carry, cell_zero;
  logic                zero_q, zero_d, carry_q, carry_d;
  logic [WIDTH-1:0]    ula_val, out_val;

  assign op_c = op_t'(op);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cel
    registrador_celula #(.WIDTH(WIDTH)) u_cel (
      .clock       (clock),
      .clear       (clear),
      .we_i        (we[g]),
      .op_i        (op_c),
      .bus_in_i    (bus_in),
      .serial_in_i (serial_in),
      .q_o         (cell_q[g]),
      .carry_o     (cell_carry[g]),
      .zero_o      (cell_zero[g])
    );
  end

  // Out-of-range selects match no cell: writes are dropped, reads give 0.
  always_comb begin
    we      = '0;
    zero_d  = zero_q;
    carry_d = carry_q;
    ula_val = '0;
    out_val = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (op_en && (op_c != OP_HOLD) && (wr_sel == SEL_W'(i))) begin
        we[i]   = 1'b1;
        zero_d  = cell_zero[i];
        carry_d = cell_carry[i];
      end
      if (ula_sel == SEL_W'(i)) ula_val = cell_q[i];
      if (out_sel == SEL_W'(i)) out_val = cell_q[i];
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign TO_ULA     = ula_val;
  assign bus_out    = out_en ? out_val : 'z;

endmodule

// File: tb/tb_registrador_universal.sv
// Self-checking bench: directed scenarios plus random ops against an
// arithmetic reference model of the register bank.
module tb_registrador_universal;

  logic       clock, clear, op_en, serial_in, out_en;
  logic [2:0] op;
  logic [1:0] wr_sel, ula_sel, out_sel;
  logic [7:0] bus_in;
  wire  [7:0] bus_w, bus_w3;
  logic [7:0] ula_w, ula_w3;
  logic       zf, cf, zf3, cf3;

  int tests = 0;
  int fails = 0;

  int m_reg [4];
  int m_z, m_c;

  logic [7:0] zz;

  registrador_universal #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clock(clock), .clear(clear), .op_en(op_en), .op(op), .wr_sel(wr_sel),
    .bus_in(bus_in), .serial_in(serial_in), .out_en(out_en),
    .ula_sel(ula_sel), .out_sel(out_sel), .bus_out(bus_w), .TO_ULA(ula_w),
    .zero_flag(zf), .carry_flag(cf)
  );

  registrador_universal #(.WIDTH(8), .NUM_REGS(3)) dut3 (
    .clock(clock), .clear(clear), .op_en(op_en), .op(op), .wr_sel(wr_sel),
    .bus_in(bus_in), .serial_in(serial_in), .out_en(out_en),
    .ula_sel(ula_sel), .out_sel(out_sel), .bus_out(bus_w3), .TO_ULA(ula_w3),
    .zero_flag(zf3), .carry_flag(cf3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_z = 0;
    m_c = 0;
  endfunction

  function automatic void model_op(input int o, input int s, input int d, input int si);
    int v, r, c;
    if (o == 0) return;
    v = m_reg[s];
    c = 0;
    r = 0;
    case (o)
      1: r = d;
      2: begin r = (v + 1) % 256;   c = (v == 255) ? 1 : 0; end
      3: begin r = (v + 255) % 256; c = (v == 0) ? 1 : 0;   end
      4: begin r = (v * 2) % 256 + si;     c = v / 128; end
      5: begin r = v / 2 + si * 128;       c = v % 2;   end
      6: begin r = (v * 2) % 256 + v / 128; c = v / 128; end
      default: r = 0;
    endcase
    m_reg[s] = r;
    m_c = c;
    m_z = (r == 0) ? 1 : 0;
  endfunction

  task automatic do_op(input logic en, input logic [2:0] o, input logic [1:0] s,
                       input logic [7:0] d, input logic si);
    op_en = en; op = o; wr_sel = s; bus_in = d; serial_in = si;
    @(posedge clock);
    #1;
    op_en = 1'b0;
    if (en) model_op(int'(o), int'(s), int'(d), int'(si));
  endtask

  task automatic peek(input int s, output logic [7:0] v);
    ula_sel = 2'(s);
    #1;
    v = ula_w;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    clear = 1'b1; op_en = 1'b0; op = 3'd0; wr_sel = 2'd0; bus_in = 8'h00;
    serial_in = 1'b0; out_en = 1'b1; out_sel = 2'd0; ula_sel = 2'd0;
    #3;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      peek(i, v);
      tests++;
      if (v !== 8'h00) begin fails++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
    end
    tests++;
    if (zf !== 1'b0 || cf !== 1'b0) begin fails++; $display("FAIL reset_flags: got z=%b c=%b want 0 0", zf, cf); end
    tests++;
    if (bus_w !== 8'h00) begin fails++; $display("FAIL reset_bus: got %h want 00", bus_w); end
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] v;
    do_op(1'b1, 3'b001, 2'd2, 8'hA5, 1'b0);
    peek(2, v);
    tests++;
    if (v !== 8'hA5) begin fails++; $display("FAIL load_r2: got %h want a5", v); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      peek(i, v);
      tests++;
      if (v !== 8'h00) begin fails++; $display("FAIL load_other_r%0d: got %h want 00", i, v); end
    end
    tests++;
    if (zf !== 1'b0 || cf !== 1'b0) begin fails++; $display("FAIL load_flags: got z=%b c=%b want 0 0", zf, cf); end
  endtask

  task automatic test_inc_dec();
    logic [7:0] v;
    do_op(1'b1, 3'b001, 2'd1, 8'hFF, 1'b0);
    do_op(1'b1, 3'b010, 2'd1, 8'h00, 1'b0);
    peek(1, v);
    tests++;
    if (v !== 8'h00 || zf !== 1'b1 || cf !== 1'b1) begin
      fails++; $display("FAIL inc_wrap: got r=%h z=%b c=%b want 00 1 1", v, zf, cf);
    end
    do_op(1'b1, 3'b011, 2'd1, 8'h00, 1'b0);
    peek(1, v);
    tests++;
    if (v !== 8'hFF || zf !== 1'b0 || cf !== 1'b1) begin
      fails++; $display("FAIL dec_borrow: got r=%h z=%b c=%b want ff 0 1", v, zf, cf);
    end
  endtask

  task automatic test_shift();
    logic [7:0] v;
    do_op(1'b1, 3'b001, 2'd0, 8'h81, 1'b0);
    do_op(1'b1, 3'b100, 2'd0, 8'h00, 1'b0);
    peek(0, v);
    tests++;
    if (v !== 8'h02 || cf !== 1'b1 || zf !== 1'b0) begin
      fails++; $display("FAIL shl: got r=%h c=%b z=%b want 02 1 0", v, cf, zf);
    end
    do_op(1'b1, 3'b101, 2'd0, 8'h00, 1'b1);
    peek(0, v);
    tests++;
    if (v !== 8'h81 || cf !== 1'b0) begin
      fails++; $display("FAIL shr: got r=%h c=%b want 81 0", v, cf);
    end
    do_op(1'b1, 3'b110, 2'd0, 8'h00, 1'b0);
    peek(0, v);
    tests++;
    if (v !== 8'h03 || cf !== 1'b1) begin
      fails++; $display("FAIL rotl: got r=%h c=%b want 03 1", v, cf);
    end
  endtask

  task automatic test_bus();
    logic [7:0] v;
    clear = 1'b1;
    #1;
    clear = 1'b0;
    model_reset();
    do_op(1'b1, 3'b001, 2'd0, 8'h11, 1'b0);
    do_op(1'b1, 3'b001, 2'd2, 8'h3C, 1'b0);
    do_op(1'b1, 3'b001, 2'd1, 8'h00, 1'b0);
    do_op(1'b1, 3'b001, 2'd3, 8'hAA, 1'b0);
    out_sel = 2'd2; out_en = 1'b0;
    #1;
    tests++;
    if (bus_w !== zz) begin fails++; $display("FAIL bus_hiz: got %h want zz", bus_w); end
    out_en = 1'b1;
    #1;
    tests++;
    if (bus_w !== 8'h3C) begin fails++; $display("FAIL bus_drive: got %h want 3c", bus_w); end
    tests++;
    if (zf !== 1'b0) begin fails++; $display("FAIL r3_load_flag: got z=%b want 0", zf); end
    tests++;
    if (zf3 !== 1'b1 || cf3 !== 1'b0) begin
      fails++; $display("FAIL oor_flags: got z=%b c=%b want 1 0", zf3, cf3);
    end
    for (int i = 0; i < 4; i++) begin
      ula_sel = 2'(i);
      #1;
      tests++;
      if (ula_w3 !== ((i == 0) ? 8'h11 : (i == 2) ? 8'h3C : 8'h00)) begin
        fails++; $display("FAIL oor_reg%0d: got %h", i, ula_w3);
      end
    end
  endtask

  task automatic test_clear_async();
    logic [7:0] v;
    do_op(1'b1, 3'b001, 2'd3, 8'hFF, 1'b0);
    do_op(1'b1, 3'b010, 2'd3, 8'h00, 1'b0);
    op_en = 1'b1; op = 3'b001; wr_sel = 2'd2; bus_in = 8'h55; out_en = 1'b1;
    #2;
    clear = 1'b1;
    #1;
    tests++;
    if (zf !== 1'b0 || cf !== 1'b0) begin fails++; $display("FAIL clr_flags: got z=%b c=%b want 0 0", zf, cf); end
    for (int i = 0; i < 4; i++) begin
      peek(i, v);
      tests++;
      if (v !== 8'h00) begin fails++; $display("FAIL clr_reg%0d: got %h want 00", i, v); end
    end
    model_reset();
    @(posedge clock);
    #1;
    peek(2, v);
    tests++;
    if (v !== 8'h00) begin fails++; $display("FAIL clr_wins: got %h want 00", v); end
    clear = 1'b0;
    do_op(1'b1, 3'b001, 2'd2, 8'h55, 1'b0);
    peek(2, v);
    tests++;
    if (v !== 8'h55 || zf !== 1'b0 || cf !== 1'b0) begin
      fails++; $display("FAIL post_clr_load: got r=%h z=%b c=%b want 55 0 0", v, zf, cf);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 3'b001, 2'd1, 8'hFD, 1'b0);
    ula_sel = 2'd1;
    for (int k = 0; k < 4; k++) begin
      op_en = 1'b1; op = 3'b010; wr_sel = 2'd1;
      #1;
      tests++;
      if (ula_w !== 8'(m_reg[1])) begin
        fails++; $display("FAIL b2b_old%0d: got %h want %h", k, ula_w, 8'(m_reg[1]));
      end
      @(posedge clock);
      model_op(2, 1, 0, 0);
      #1;
      tests++;
      if (ula_w !== 8'(m_reg[1]) || zf !== m_z[0] || cf !== m_c[0]) begin
        fails++; $display("FAIL b2b_new%0d: got r=%h z=%b c=%b want %h %0d %0d",
                          k, ula_w, zf, cf, 8'(m_reg[1]), m_z, m_c);
      end
    end
    op_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       en;
    logic [2:0] o;
    logic [1:0] s, rs;
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 3) != 0);
      o  = 3'($urandom_range(0, 7));
      s  = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      do_op(en, o, s, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      peek(int'(s), v);
      tests++;
      if (v !== 8'(m_reg[s]) || zf !== m_z[0] || cf !== m_c[0]) begin
        fails++; $display("FAIL rand%0d op=%0d sel=%0d: got r=%h z=%b c=%b want %h %0d %0d",
                          n, o, s, v, zf, cf, 8'(m_reg[s]), m_z, m_c);
      end
      peek(int'(rs), v);
      tests++;
      if (v !== 8'(m_reg[rs])) begin
        fails++; $display("FAIL rand_read%0d sel=%0d: got %h want %h", n, rs, v, 8'(m_reg[rs]));
      end
    end
  endtask

  initial begin
    zz = 8'bzzzzzzzz;
    test_reset();
    test_load();
    test_inc_dec();
    test_shift();
    test_bus();
    test_clear_async();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
